// File: rtl/eth_pkg.sv
// Shared constants and state encoding for the Ethernet payload transmitter.
package eth_pkg;

  localparam int MIN_PAYLOAD    = 46;
  localparam int PREAMBLE_BYTES = 8;
  localparam int HEADER_BYTES   = 14;

  typedef enum logic [2:0] {
    FILL,
    START,
    HOLD,
    SEND,
    PAD,
    GAP
  } state_t;

endpackage

// File: rtl/payload_ram.sv
// Payload byte buffer: one write port, one registered read port, contents not reset.
module payload_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [7:0]    wd,
  input  logic [AW-1:0] ra,
  output logic [7:0]    rd
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end

endmodule

// File: rtl/eth_payload_tx.sv
// Buffers one packet of payload bytes, then streams it N bits per clock after a
// start strobe and header hold, zero-padding short payloads to the Ethernet minimum.
module eth_payload_tx
  import eth_pkg::*;
#(
  parameter int N          = 2,
  parameter int DEPTH      = 64,
  parameter int HDR_CYCLES = 176,
  parameter int GAP_CYCLES = 96 / N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   wr_data,
  input  logic         wr_valid,
  input  logic         wr_last,
  output logic         wr_ready,
  output logic         axiov,
  output logic [N-1:0] axiod,
  output logic         busy
);

  localparam int SPB = 8 / N;
  localparam int SW  = (SPB > 1) ? $clog2(SPB) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int TW  = $clog2(HDR_CYCLES + GAP_CYCLES + MIN_PAYLOAD * 8 + 1);
  localparam logic [CW-1:0] MIN_CNT = CW'(MIN_PAYLOAD);

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic [AW-1:0] byte_idx, byte_idx_n, rd_addr;
  logic [SW-1:0] sym, sym_n;
  logic [TW-1:0] tmr, tmr_n, pad_len;
  logic          ready_q, hs, last_sym;
  logic [7:0]    rd_data, sh;

  assign hs       = wr_valid & ready_q;
  assign wr_ready = ready_q;
  assign busy     = (state != FILL);
  assign last_sym = (sym == SW'(SPB - 1));
  assign pad_len  = TW'((MIN_PAYLOAD - int'(count)) * SPB);
  // Fetch one byte ahead so the registered read lines up with the symbol counter.
  assign rd_addr  = (state == SEND && last_sym) ? byte_idx + AW'(1) : byte_idx;

  payload_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk (clk),
    .we  (hs),
    .wa  (count[AW-1:0]),
    .wd  (wr_data),
    .ra  (rd_addr),
    .rd  (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FILL;
      count    <= '0;
      byte_idx <= '0;
      sym      <= '0;
      tmr      <= '0;
      ready_q  <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      byte_idx <= byte_idx_n;
      sym      <= sym_n;
      tmr      <= tmr_n;
      ready_q  <= (state_n == FILL);
    end
  end

  always_comb begin
    state_n    = state;
    count_n    = count;
    byte_idx_n = byte_idx;
    sym_n      = sym;
    tmr_n      = tmr;
    axiov      = 1'b0;
    axiod      = '0;
    sh         = rd_data << (N * sym);
    case (state)
      FILL: if (hs) begin
        count_n = count + CW'(1);
        if (wr_last || count == CW'(DEPTH - 1)) state_n = START;
      end
      START: begin
        axiov   = 1'b1;
        tmr_n   = '0;
        state_n = HOLD;
      end
      HOLD: if (tmr == TW'(HDR_CYCLES - 1)) begin
        tmr_n   = '0;
        state_n = SEND;
      end else tmr_n = tmr + TW'(1);
      SEND: begin
        axiov = 1'b1;
        axiod = sh[7 -: N];
        sym_n = sym + SW'(1);
        if (last_sym) begin
          if ({1'b0, byte_idx} == count - CW'(1)) begin
            byte_idx_n = '0;
            tmr_n      = '0;
            state_n    = (count < MIN_CNT) ? PAD : GAP;
          end else byte_idx_n = byte_idx + AW'(1);
        end
      end
      PAD: begin
        axiov = 1'b1;
        if (tmr == pad_len - TW'(1)) begin
          tmr_n   = '0;
          state_n = GAP;
        end else tmr_n = tmr + TW'(1);
      end
      GAP: if (tmr == TW'(GAP_CYCLES - 1)) begin
        tmr_n   = '0;
        count_n = '0;
        state_n = FILL;
      end else tmr_n = tmr + TW'(1);
      default: state_n = FILL;
    endcase
  end

endmodule

// File: tb/tb_eth_payload_tx.sv
// Directed bench for eth_payload_tx: an N=2 and an N=4 instance share stimulus,
// with sel steering wr_valid and the observed outputs.
module tb_eth_payload_tx;

  localparam int HDR2 = 176, GAP2 = 48, HDR4 = 88, GAP4 = 24;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_valid, wr_last, sel;
  logic       wr_ready2, axiov2, busy2;
  logic [1:0] axiod2;
  logic       wr_ready4, axiov4, busy4;
  logic [3:0] axiod4;
  logic       obs_v, obs_b, obs_r;
  logic [3:0] obs_d;
  logic [7:0] pkt [$];
  int         vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  eth_payload_tx #(.N(2), .DEPTH(64), .HDR_CYCLES(HDR2), .GAP_CYCLES(GAP2)) u_dut2 (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid & ~sel),
    .wr_last(wr_last), .wr_ready(wr_ready2), .axiov(axiov2), .axiod(axiod2), .busy(busy2)
  );

  eth_payload_tx #(.N(4), .DEPTH(64), .HDR_CYCLES(HDR4), .GAP_CYCLES(GAP4)) u_dut4 (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid & sel),
    .wr_last(wr_last), .wr_ready(wr_ready4), .axiov(axiov4), .axiod(axiod4), .busy(busy4)
  );

  assign obs_v = sel ? axiov4 : axiov2;
  assign obs_b = sel ? busy4 : busy2;
  assign obs_r = sel ? wr_ready4 : wr_ready2;
  assign obs_d = sel ? axiod4 : {2'b00, axiod2};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_pkt(input bit use_last);
    for (int i = 0; i < pkt.size(); i++) begin
      int t = 0;
      wr_data  = pkt[i];
      wr_last  = use_last && (i == pkt.size() - 1);
      wr_valid = 1'b1;
      while (obs_r !== 1'b1 && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("wr ready byte %0d", i), 8'(obs_r), 8'd1);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  // Called at the negedge of the START cycle; walks the whole frame cycle by cycle.
  task automatic frame_chk(input string tag, input int nb, input int n, input int hdr,
                           input int gap, input int drop_at);
    int spb   = 8 / n;
    int pad   = (nb < 46) ? (46 - nb) * spb : 0;
    int total = 1 + hdr + nb * spb + pad + gap;
    for (int c = 0; c < total; c++) begin
      logic       ev;
      logic [3:0] ed;
      bit         dchk;
      int         k;
      if (c == drop_at) wr_valid = 1'b0;
      ev = 1'b0; ed = 4'd0; dchk = 1'b1; k = 0;
      if (c == 0) ev = 1'b1;
      else if (c < 1 + hdr) ev = 1'b0;
      else if (c < 1 + hdr + nb * spb) begin
        k  = c - 1 - hdr;
        ev = 1'b1;
        ed = 4'((pkt[k / spb] >> (8 - n * (k % spb + 1))) & ((1 << n) - 1));
      end else if (c < 1 + hdr + nb * spb + pad) ev = 1'b1;
      else dchk = 1'b0;
      chk($sformatf("%s axiov c%0d", tag, c), 8'(obs_v), 8'(ev));
      if (dchk) chk($sformatf("%s axiod c%0d", tag, c), 8'(obs_d), 8'(ed));
      chk($sformatf("%s busy c%0d", tag, c), 8'(obs_b), 8'd1);
      chk($sformatf("%s wr_ready c%0d", tag, c), 8'(obs_r), 8'd0);
      @(negedge clk);
    end
    chk($sformatf("%s busy after gap", tag), 8'(obs_b), 8'd0);
    chk($sformatf("%s wr_ready after gap", tag), 8'(obs_r), 8'd1);
  endtask

  initial begin
    rst = 1'b0; wr_data = 8'h00; wr_valid = 1'b0; wr_last = 1'b0; sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst axiov2", 8'(axiov2), 8'd0);
    chk("rst axiod2", 8'(axiod2), 8'd0);
    chk("rst ready2", 8'(wr_ready2), 8'd0);
    chk("rst busy2", 8'(busy2), 8'd0);
    chk("rst axiov4", 8'(axiov4), 8'd0);
    chk("rst ready4", 8'(wr_ready4), 8'd0);
    rst = 1'b1;
    #1 chk("ready before first edge", 8'(wr_ready2), 8'd0);
    @(negedge clk);
    chk("ready after first edge 2", 8'(wr_ready2), 8'd1);
    chk("ready after first edge 4", 8'(wr_ready4), 8'd1);

    // Two-byte packet, then wr_valid held high through the whole frame.
    pkt = '{8'hEB, 8'h12};
    wr_pkt(1'b1);
    wr_data = 8'h77; wr_last = 1'b1; wr_valid = 1'b1;
    frame_chk("p2byte", 2, 2, HDR2, GAP2, -1);
    @(negedge clk);
    wr_valid = 1'b0; wr_last = 1'b0;
    pkt = '{8'h77};
    frame_chk("pheld", 1, 2, HDR2, GAP2, -1);

    // Full buffer, no wr_last; a 65th byte is offered while full.
    pkt.delete();
    for (int i = 0; i < 64; i++) pkt.push_back(8'((i * 7 + 3) & 255));
    wr_pkt(1'b0);
    wr_data = 8'hC3; wr_last = 1'b1; wr_valid = 1'b1;
    chk("p64 full ready", 8'(obs_r), 8'd0);
    frame_chk("p64", 64, 2, HDR2, GAP2, 10);

    // N=4, 60 bytes, no padding.
    sel = 1'b1;
    pkt.delete();
    for (int i = 0; i < 60; i++) pkt.push_back(8'(i));
    wr_pkt(1'b1);
    frame_chk("n4p60", 60, 4, HDR4, GAP4, -1);

    // Reset in the middle of SEND, then a 1-byte padded packet.
    sel = 1'b0;
    pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    wr_pkt(1'b1);
    repeat (1 + HDR2 + 6) @(negedge clk);
    chk("midsend axiov", 8'(axiov2), 8'd1);
    rst = 1'b0;
    #1;
    chk("midrst axiov", 8'(axiov2), 8'd0);
    chk("midrst axiod", 8'(axiod2), 8'd0);
    chk("midrst busy", 8'(busy2), 8'd0);
    chk("midrst ready", 8'(wr_ready2), 8'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rerelease ready low", 8'(wr_ready2), 8'd0);
    @(negedge clk);
    chk("rerelease ready high", 8'(wr_ready2), 8'd1);
    pkt = '{8'hA5};
    wr_pkt(1'b1);
    frame_chk("pA5", 1, 2, HDR2, GAP2, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
